fir_axil_master: RTL

FIR_AXIL_MASTER -- requirements
Module: fir_axil_master

---
 rtl/fir_axil_master.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/fir_axil_master.sv
// Single-outstanding AXI4-Lite master: turns one user command into an AXI-Lite
// read or write and hands back the slave's response on a valid/ready port.
module fir_axil_master #(
    parameter int C_M_AXI_DATA_WIDTH = 32,
    parameter int C_M_AXI_ADDR_WIDTH = 5
) (
    input  logic                            M_AXI_ACLK,
    input  logic                            M_AXI_ARESETN,
    input  logic                            cmd_valid,
    output logic                            cmd_ready,
    input  logic                            cmd_write,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [C_M_AXI_DATA_WIDTH/8-1:0] cmd_wstrb,
    output logic                            rsp_valid,
    input  logic                            rsp_ready,
    output logic [C_M_AXI_DATA_WIDTH-1:0]   rsp_rdata,
    output logic [1:0]                      rsp_resp,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
    output logic                            M_AXI_AWVALID,
    input  logic                            M_AXI_AWREADY,
    output logic [2:0]                      M_AXI_AWPROT,
    output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
    output logic                            M_AXI_WVALID,
    input  logic                            M_AXI_WREADY,
    input  logic [1:0]                      M_AXI_BRESP,
    input  logic                            M_AXI_BVALID,
    output logic                            M_AXI_BREADY,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
    output logic                            M_AXI_ARVALID,
    input  logic                            M_AXI_ARREADY,
    output logic [2:0]                      M_AXI_ARPROT,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
    input  logic [1:0]                      M_AXI_RRESP,
    input  logic                            M_AXI_RVALID,
    output logic                            M_AXI_RREADY
);

    typedef enum logic [2:0] {
        IDLE,
        WR_ADDR_DATA,
        WR_RESP,
        RD_ADDR,
        RD_DATA,
        RESP
    } state_t;

    state_t                            state_reg;
    logic [C_M_AXI_ADDR_WIDTH-1:0]     addr_reg;
    logic [C_M_AXI_DATA_WIDTH-1:0]     wdata_reg;
    logic [C_M_AXI_DATA_WIDTH/8-1:0]   wstrb_reg;
    logic                              aw_done;
    logic                              w_done;

    // Address, data and strobes come straight from the latched command, so
    // they cannot move while the corresponding VALID is high.
    assign M_AXI_AWADDR = addr_reg;
    assign M_AXI_ARADDR = addr_reg;
    assign M_AXI_WDATA  = wdata_reg;
    assign M_AXI_WSTRB  = wstrb_reg;
    assign M_AXI_AWPROT = 3'b000;
    assign M_AXI_ARPROT = 3'b000;

    // A channel is done once its VALID has dropped or is handshaking now.
    assign aw_done = !M_AXI_AWVALID || M_AXI_AWREADY;
    assign w_done  = !M_AXI_WVALID  || M_AXI_WREADY;

    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) begin
            state_reg     <= IDLE;
            cmd_ready     <= 1'b0;
            addr_reg      <= '0;
            wdata_reg     <= '0;
            wstrb_reg     <= '0;
            M_AXI_AWVALID <= 1'b0;
            M_AXI_WVALID  <= 1'b0;
            M_AXI_BREADY  <= 1'b0;
            M_AXI_ARVALID <= 1'b0;
            M_AXI_RREADY  <= 1'b0;
            rsp_valid     <= 1'b0;
            rsp_rdata     <= '0;
            rsp_resp      <= 2'b00;
        end else begin
            case (state_reg)
                IDLE: begin
                    cmd_ready <= 1'b1;
                    if (cmd_valid && cmd_ready) begin
                        cmd_ready <= 1'b0;
                        addr_reg  <= cmd_addr;
                        wdata_reg <= cmd_wdata;
                        wstrb_reg <= cmd_wstrb;
                        if (cmd_write) begin
                            M_AXI_AWVALID <= 1'b1;
                            M_AXI_WVALID  <= 1'b1;
                            state_reg     <= WR_ADDR_DATA;
                        end else begin
                            M_AXI_ARVALID <= 1'b1;
                            state_reg     <= RD_ADDR;
                        end
                    end
                end
                WR_ADDR_DATA: begin
                    if (M_AXI_AWVALID && M_AXI_AWREADY) M_AXI_AWVALID <= 1'b0;
                    if (M_AXI_WVALID && M_AXI_WREADY)   M_AXI_WVALID  <= 1'b0;
                    if (aw_done && w_done) begin
                        M_AXI_BREADY <= 1'b1;
                        state_reg    <= WR_RESP;
                    end
                end
                WR_RESP: begin
                    if (M_AXI_BVALID) begin
                        M_AXI_BREADY <= 1'b0;
                        rsp_rdata    <= '0;
                        rsp_resp     <= M_AXI_BRESP;
                        rsp_valid    <= 1'b1;
                        state_reg    <= RESP;
                    end
                end
                RD_ADDR: begin
                    if (M_AXI_ARREADY) begin
                        M_AXI_ARVALID <= 1'b0;
                        M_AXI_RREADY  <= 1'b1;
                        state_reg     <= RD_DATA;
                    end
                end
                RD_DATA: begin
                    if (M_AXI_RVALID) begin
                        M_AXI_RREADY <= 1'b0;
                        rsp_rdata    <= M_AXI_RDATA;
                        rsp_resp     <= M_AXI_RRESP;
                        rsp_valid    <= 1'b1;
                        state_reg    <= RESP;
                    end
                end
                RESP: begin
                    // Re-arming cmd_ready here lets the next command land the
                    // cycle after the response is taken.
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule
